// File: rtl/b2bcd_seq_conv_if.sv
// Handshake and data bundle for the sequential binary-to-BCD converter.
// The slave modport is the converter side and the master modport is the producer/consumer side.
interface b2bcd_seq_conv_if #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 10,
  parameter int ND_W  = $clog2(DIGIT+1)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     Binary_code;
  logic                 in_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGIT-1:0]   BCD_code;
  logic                 out_neg;
  logic                 out_ovf;
  logic [ND_W-1:0]      num_digits;

  modport slave (
    input  in_valid, Binary_code, in_signed, out_ready,
    output in_ready, out_valid, BCD_code, out_neg, out_ovf, num_digits
  );

  modport master (
    output in_valid, Binary_code, in_signed, out_ready,
    input  in_ready, out_valid, BCD_code, out_neg, out_ovf, num_digits
  );
endinterface

// File: rtl/b2bcd_seq_conv.sv
// Iterative double-dabble binary-to-BCD converter that processes one input bit per clock.
// It has valid/ready on both sides, a two's-complement mode, overflow detection and a significant-digit count.

// Per-digit add-3 correction applied before each shift.
module b2bcd_dig_adj (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);
  assign dig_o = (dig_i > 4'd4) ? dig_i + 4'd3 : dig_i;
endmodule

module b2bcd_seq_conv #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 10,
  parameter int CNT_W = $clog2(WIDTH+1),
  parameter int ND_W  = $clog2(DIGIT+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  b2bcd_seq_conv_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [4*DIGIT-1:0]   bcd_q, bcd_d;
  logic                 neg_q, neg_d;
  logic                 ovf_q, ovf_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [4*DIGIT-1:0]   code_q, code_d;
  logic                 oneg_q, oneg_d;
  logic                 oovf_q, oovf_d;
  logic [ND_W-1:0]      nd_q, nd_d;

  logic [4*DIGIT-1:0]   adj;
  logic [4*DIGIT-1:0]   bcd_sh;
  logic [WIDTH-1:0]     bin_sh;
  logic                 ovf_sh;
  logic [ND_W-1:0]      nd_sh;
  logic                 neg_in;

  // Every digit is corrected independently. Carries never cross digit boundaries.
  for (genvar g = 0; g < DIGIT; g++) begin : g_dig
    b2bcd_dig_adj u_adj (.dig_i(bcd_q[4*g +: 4]), .dig_o(adj[4*g +: 4]));
  end

  // {bcd, bin} shifts left by one. A 1 leaving the top digit means the value exceeds DIGIT digits.
  assign bcd_sh = {adj[4*DIGIT-2:0], bin_q[WIDTH-1]};
  assign bin_sh = {bin_q[WIDTH-2:0], 1'b0};
  assign ovf_sh = ovf_q | adj[4*DIGIT-1];
  assign neg_in = bus.in_signed & bus.Binary_code[WIDTH-1];

  // Significant-digit count of the (truncated) result that is about to complete, minimum 1.
  always_comb begin
    nd_sh = ND_W'(1);
    for (int i = 1; i < DIGIT; i++)
      if (bcd_sh[4*i +: 4] != 4'd0) nd_sh = ND_W'(i + 1);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    code_d      = code_q;
    oneg_d      = oneg_q;
    oovf_d      = oovf_q;
    nd_d        = nd_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          // -2^(WIDTH-1) negates to itself. That bit pattern read as unsigned is the correct magnitude.
          bin_d      = neg_in ? (~bus.Binary_code + WIDTH'(1)) : bus.Binary_code;
          neg_d      = neg_in;
          bcd_d      = '0;
          ovf_d      = 1'b0;
          cnt_d      = CNT_W'(WIDTH);
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        ovf_d = ovf_sh;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          code_d      = bcd_sh;
          oneg_d      = neg_q;
          oovf_d      = ovf_sh;
          nd_d        = nd_sh;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers. Reset aborts any conversion that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      code_q      <= '0;
      oneg_q      <= 1'b0;
      oovf_q      <= 1'b0;
      nd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      oneg_q      <= oneg_d;
      oovf_q      <= oovf_d;
      nd_q        <= nd_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.BCD_code   = code_q;
  assign bus.out_neg    = oneg_q;
  assign bus.out_ovf    = oovf_q;
  assign bus.num_digits = nd_q;
endmodule

// File: tb/tb_b2bcd_seq_conv.sv
// Scoreboard bench for b2bcd_seq_conv.
// Unit A is 32-bit/10-digit and unit B is 16-bit/4-digit, which exercises the overflow cases.
module tb_b2bcd_seq_conv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  b2bcd_seq_conv_if #(.WIDTH(32), .DIGIT(10)) ifA ();
  b2bcd_seq_conv_if #(.WIDTH(16), .DIGIT(4))  ifB ();

  b2bcd_seq_conv #(.WIDTH(32), .DIGIT(10)) uA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  b2bcd_seq_conv #(.WIDTH(16), .DIGIT(4))  uB (.clk(clk), .rst_n(rst_n), .bus(ifB));

  typedef struct {
    logic [39:0] bcd;
    logic        neg;
    logic        ovf;
    logic [3:0]  nd;
    int          acc;
  } exp_t;

  exp_t sbA[$];
  exp_t sbB[$];
  logic pvA = 1'b0;
  logic pvB = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pops one expected result and compares it with what the selected unit presents.
  task automatic mon(input bit b);
    exp_t e;
    if (!b) begin
      if (sbA.size() == 0) chk("A unexpected out_valid", 1, 0);
      else begin
        e = sbA.pop_front();
        chk("A BCD_code", 64'(ifA.BCD_code), 64'(e.bcd));
        chk("A out_neg", 64'(ifA.out_neg), 64'(e.neg));
        chk("A out_ovf", 64'(ifA.out_ovf), 64'(e.ovf));
        chk("A num_digits", 64'(ifA.num_digits), 64'(e.nd));
        chk("A latency", 64'(cyc), 64'(e.acc + 32));
      end
    end else begin
      if (sbB.size() == 0) chk("B unexpected out_valid", 1, 0);
      else begin
        e = sbB.pop_front();
        chk("B BCD_code", 64'(ifB.BCD_code), 64'(e.bcd));
        chk("B out_neg", 64'(ifB.out_neg), 64'(e.neg));
        chk("B out_ovf", 64'(ifB.out_ovf), 64'(e.ovf));
        chk("B num_digits", 64'(ifB.num_digits), 64'(e.nd));
        chk("B latency", 64'(cyc), 64'(e.acc + 16));
      end
    end
  endtask

  // Monitor: checks each result on the sample where out_valid rises.
  always @(negedge clk) begin
    if (ifA.out_valid && !pvA) mon(1'b0);
    if (ifB.out_valid && !pvB) mon(1'b1);
    pvA <= ifA.out_valid;
    pvB <= ifB.out_valid;
  end

  // Waits (bounded) for in_ready, then issues one word and records the expected result.
  task automatic send(input bit b, input logic [31:0] v, input logic s,
                      input logic [39:0] bcd, input logic neg, input logic ovf, input logic [3:0] nd);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!(b ? ifB.in_ready : ifA.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(b ? "B in_ready wait" : "A in_ready wait", 64'(b ? ifB.in_ready : ifA.in_ready), 1);
    e.bcd = bcd; e.neg = neg; e.ovf = ovf; e.nd = nd; e.acc = cyc + 1;
    if (b) begin
      sbB.push_back(e);
      ifB.Binary_code = v[15:0]; ifB.in_signed = s; ifB.in_valid = 1'b1;
    end else begin
      sbA.push_back(e);
      ifA.Binary_code = v; ifA.in_signed = s; ifA.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    ifA.in_valid = 1'b0;
    ifB.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    ifA.in_valid = 1'b0; ifA.Binary_code = '0; ifA.in_signed = 1'b0; ifA.out_ready = 1'b1;
    ifB.in_valid = 1'b0; ifB.Binary_code = '0; ifB.in_signed = 1'b0; ifB.out_ready = 1'b1;

    // Check the reset state, then check that in_ready rises one edge after release.
    repeat (2) @(negedge clk);
    chk("rst A in_ready", 64'(ifA.in_ready), 0);
    chk("rst A out_valid", 64'(ifA.out_valid), 0);
    chk("rst A BCD_code", 64'(ifA.BCD_code), 0);
    chk("rst A num_digits", 64'(ifA.num_digits), 0);
    chk("rst B in_ready", 64'(ifB.in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst A in_ready", 64'(ifA.in_ready), 1);
    chk("post-rst B in_ready", 64'(ifB.in_ready), 1);

    // Unsigned and signed vectors on the wide unit.
    send(0, 32'd1234567890, 0, 40'h1234567890, 0, 0, 4'd10);
    send(0, 32'd0,          0, 40'h0,          0, 0, 4'd1);
    send(0, 32'hFFFFFFFF,   0, 40'h4294967295, 0, 0, 4'd10);
    send(0, 32'hFFFFFFFF,   1, 40'h1,          1, 0, 4'd1);
    send(0, 32'h80000000,   1, 40'h2147483648, 1, 0, 4'd10);
    send(0, 32'h0000007B,   1, 40'h123,        0, 0, 4'd3);

    // Overflow cases on the narrow unit.
    send(1, 32'd65535, 0, 40'h5535, 0, 1, 4'd4);
    send(1, 32'd9999,  0, 40'h9999, 0, 0, 4'd4);
    send(1, 32'd10000, 0, 40'h0000, 0, 1, 4'd1);
    send(1, 32'h8000,  1, 40'h2768, 1, 1, 4'd4);

    // Backpressure: results stay put and a new word offered during DONE is ignored.
    ifA.out_ready = 1'b0;
    send(0, 32'd42, 0, 40'h42, 0, 0, 4'd2);
    n = 0;
    while (!ifA.out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp out_valid rise", 64'(ifA.out_valid), 1);
    ifA.Binary_code = 32'd999; ifA.in_signed = 1'b0; ifA.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp out_valid held", 64'(ifA.out_valid), 1);
      chk("bp in_ready low", 64'(ifA.in_ready), 0);
      chk("bp BCD_code held", 64'(ifA.BCD_code), 64'h42);
      chk("bp num_digits held", 64'(ifA.num_digits), 2);
    end
    ifA.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 64'(ifA.out_valid), 0);
    chk("bp release in_ready", 64'(ifA.in_ready), 1);
    ifA.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp word not taken", 64'(ifA.in_ready), 1);

    // Reset after 10 SHIFT edges aborts the conversion, and the next conversion is clean.
    send(0, 32'd1234567890, 0, 40'h1234567890, 0, 0, 4'd10);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbA.delete();
    #1;
    chk("abort in_ready", 64'(ifA.in_ready), 0);
    chk("abort out_valid", 64'(ifA.out_valid), 0);
    chk("abort BCD_code", 64'(ifA.BCD_code), 0);
    chk("abort out_neg", 64'(ifA.out_neg), 0);
    chk("abort out_ovf", 64'(ifA.out_ovf), 0);
    chk("abort num_digits", 64'(ifA.num_digits), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release in_ready still low", 64'(ifA.in_ready), 0);
    @(posedge clk); #1;
    chk("release in_ready", 64'(ifA.in_ready), 1);
    repeat (40) @(negedge clk);
    send(0, 32'd86400, 0, 40'h86400, 0, 0, 4'd5);

    // Wait for outstanding results to drain.
    n = 0;
    while ((sbA.size() != 0 || sbB.size() != 0) && n < 200) begin @(negedge clk); n++; end
    chk("scoreboard drained", 64'(sbA.size() + sbB.size()), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/b2bcd_seq_conv.md
Name: b2bcd_seq_conv

Overview:
Sequential, parametrised binary-to-BCD converter using iterative double-dabble (add-3 then shift), one input bit per clock. It is the resource-light successor to the combinational B2BCD IP and is used by the UnixTime datapath when converting wide counters (seconds, epoch values) where a fully unrolled tree is too large. It adds a valid/ready handshake on both sides, a signed mode, overflow detection and a significant-digit count.

Parameters:
WIDTH, 32, binary input width (>=4)
DIGIT, 10, number of BCD digits produced (>=1)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)
ND_W, $clog2(DIGIT+1), width of num_digits (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  converter can accept a word
Binary_code  input  WIDTH  binary operand
in_signed  input  1  treat Binary_code as two's complement; sampled with Binary_code
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
BCD_code  output  4*DIGIT  result {..., hundreds, tens, ones}
out_neg  output  1  result is negative (magnitude in BCD_code)
out_ovf  output  1  value did not fit in DIGIT digits
num_digits  output  ND_W  count of significant digits (1 for value 0)

Behaviour:
- One clock domain, rst_n asynchronous assert, synchronous release. All registers reset immediately on assertion.
- Reset values: in_ready=0, out_valid=0, BCD_code=0, out_neg=0, out_ovf=0, num_digits=0, FSM=IDLE, counter=0.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - Capture the magnitude into the shift register: Binary_code, or its two's-complement negation when in_signed=1 and Binary_code[WIDTH-1]=1.
  - Capture the negative flag. Clear the working BCD register and the overflow flag. Set counter=WIDTH.
  - Set in_ready=0 and go to SHIFT.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and is held as WIDTH-bit unsigned.
- SHIFT: on each edge:
  - Every working digit >4 gets +3 (4-bit add, no carry between digits).
  - Then {bcd, bin} shifts left by 1.
  - Any 1 shifted out of the top digit sets sticky ovf. Counter decrements.
  - The edge where counter goes 1->0 does all of the following: copies the working BCD to BCD_code, latches out_neg, out_ovf and num_digits, sets out_valid=1, and goes to DONE.
- Latency: if the accept is at edge T, out_valid is high after edge T+WIDTH.
- DONE: out_valid, BCD_code, out_neg, out_ovf and num_digits are held stable while out_ready=0. in_valid is ignored.
  - On an edge with out_ready=1: out_valid=0, in_ready=1, go to IDLE.
  - Result outputs retain their last values until the next conversion completes.
- Throughput: at most one conversion per WIDTH+2 cycles. No overlap of accept and output handshake.
- num_digits = index of the highest nonzero digit + 1. It is 1 when the result is 0 and is computed on the truncated result.
- When DIGIT >= ceil(WIDTH*log10 2), out_ovf is always 0. Otherwise BCD_code holds the value mod 10^DIGIT and out_ovf=1 whenever the value is >= 10^DIGIT.
- out_neg=0 whenever in_signed=0. -0 cannot occur.
- Reset asserted mid-SHIFT or mid-DONE aborts the conversion with no output. The first accept after release converts correctly.
- in_valid/Binary_code/in_signed are don't-care outside IDLE. out_ready is don't-care outside DONE.

Test Plan:
1. WIDTH=32, DIGIT=10, unsigned Binary_code=1234567890 accepted at edge T -> out_valid rises after edge T+32. BCD_code=40'h1234567890, num_digits=10, out_ovf=0, out_neg=0.
2. Binary_code=0 -> BCD_code=0, num_digits=1. Then 32'hFFFFFFFF unsigned -> 40'h4294967295, num_digits=10.
3. in_signed=1:
   - 32'hFFFFFFFF -> BCD_code=1, out_neg=1, num_digits=1.
   - 32'h80000000 -> 40'h2147483648, out_neg=1.
   - 32'h0000007B -> 40'h123, out_neg=0, num_digits=3.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with a new word. Outputs stay stable, in_ready stays 0 and the new word is not taken. Raising out_ready gives out_valid=0 and in_ready=1 on the next edge.
5. Overflow (WIDTH=16, DIGIT=4):
   - 65535 -> BCD_code=16'h5535, out_ovf=1, num_digits=4.
   - 9999 -> 16'h9999, out_ovf=0.
   - 10000 -> 16'h0000, out_ovf=1, num_digits=1.
6. Reset mid-operation: assert rst_n=0 after 10 SHIFT cycles. All outputs go to reset values without waiting for a clock edge, and no out_valid appears. After release, in_ready=1 one edge later, and converting 86400 gives 40'h86400.
